// File: rtl/game_timer_ctrl_pkg.sv
// Shared definitions for the level countdown controller: field widths,
// state encoding and the saturating bonus-time adder.
package game_timer_ctrl_pkg;

  localparam int TIME_W  = 12;
  localparam int LIVES_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_TOUT   = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // One extra bit on the sum so a large bonus can never wrap time_left.
  function automatic logic [TIME_W-1:0] sat_add(
    input logic [TIME_W-1:0] t,
    input logic [TIME_W-1:0] bonus,
    input logic [TIME_W-1:0] max_t
  );
    logic [TIME_W:0] sum;
    sum = {1'b0, t} + {1'b0, bonus};
    return (sum > {1'b0, max_t}) ? max_t : sum[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/game_timer_ctrl_tick_gen.sv
// Countdown prescaler: counts 0..DIV-1 while enabled, holds otherwise.
// wrap flags the cycle in which the count returns to zero.
module game_timer_ctrl_tick_gen #(
  parameter int DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign wrap = en && !clr && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Per-level countdown sequencer: start/pause, 1 s tick enable, bonus time,
// level-change reload, time-out and life accounting. All outputs registered.
module game_timer_ctrl
  import game_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int INIT_TIME  = 60,
  parameter int BONUS_TIME = 5,
  parameter int MAX_TIME   = 999,
  parameter int LIVES      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic [9:0]  lvl,
  input  logic        add_time,
  output logic [11:0] time_left,
  output logic        tick,
  output logic        time_out,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic [2:0]  state
);

  localparam logic [TIME_W-1:0]  INIT_T  = TIME_W'(INIT_TIME);
  localparam logic [TIME_W-1:0]  BONUS_T = TIME_W'(BONUS_TIME);
  localparam logic [TIME_W-1:0]  MAX_T   = TIME_W'(MAX_TIME);
  localparam logic [LIVES_W-1:0] LIVES_L = LIVES_W'(LIVES);

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   time_q, time_d, bumped;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [9:0]          lvl_q, lvl_d;
  logic                tick_q, tick_d;
  logic                tout_q, tout_d;
  logic                over_q;
  logic                lvl_chg, active;
  logic                pre_en, pre_clr, wrap;

  assign active  = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign lvl_chg = (lvl != lvl_q);
  // A pause pulse on a wrap cycle freezes the prescaler so the dropped wrap is taken after resume.
  assign pre_en  = (state_q == ST_RUN) && !pause;
  assign pre_clr = !active || lvl_chg;

  game_timer_ctrl_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .wrap (wrap)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    lives_d = lives_q;
    lvl_d   = lvl_q;
    tick_d  = 1'b0;
    tout_d  = 1'b0;
    bumped  = add_time ? sat_add(time_q, BONUS_T, MAX_T) : time_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        lvl_d = lvl;
        if (start) begin
          state_d = ST_RUN;
          time_d  = INIT_T;
          lives_d = LIVES_L;
        end
      end
      ST_TOUT: begin
        lvl_d = lvl;
        if (lives_q > LIVES_W'(1)) begin
          lives_d = lives_q - LIVES_W'(1);
          time_d  = INIT_T;
          state_d = ST_RUN;
        end else begin
          lives_d = '0;
          state_d = ST_OVER;
        end
      end
      ST_RUN, ST_PAUSED: begin
        if (lvl_chg) begin
          lvl_d  = lvl;
          time_d = INIT_T;
        end else if (pause) begin
          state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end else if (state_q == ST_RUN) begin
          if (wrap) begin
            time_d = bumped - TIME_W'(1);
            tick_d = 1'b1;
            if (bumped == TIME_W'(1)) begin
              state_d = ST_TOUT;
              tout_d  = 1'b1;
            end
          end else begin
            time_d = bumped;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      time_q  <= INIT_T;
      lives_q <= LIVES_L;
      lvl_q   <= lvl;
      tick_q  <= 1'b0;
      tout_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      lives_q <= lives_d;
      lvl_q   <= lvl_d;
      tick_q  <= tick_d;
      tout_q  <= tout_d;
      over_q  <= (state_d == ST_OVER);
    end
  end

  assign time_left = time_q;
  assign tick      = tick_q;
  assign time_out  = tout_q;
  assign lives     = lives_q;
  assign game_over = over_q;
  assign state     = state_q;

endmodule
